fifo_wr_arbiter: RTL and testbench

//   Shares the single write port of one Fifo instance among NREQ producers, e.g. shader

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one Fifo write port among NREQ producers.
// Latency: grant registered one edge after a valid request is seen in IDLE; write path is combinational.
// Backpressure: fifo_full gates req_ready/fifo_wrreq combinationally; grant and burst count hold while full.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int BW       = 32,
   parameter int MAXBURST = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*BW-1:0]  req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic [BW-1:0]       fifo_data,
   output logic                fifo_wrreq,
   input  logic                fifo_full,
   output logic [NREQ-1:0]     grant,
   output logic                busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAXBURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   pick;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            xfer;
   logic            rel;

   // Round-robin pick: scan rr_ptr+1 .. rr_ptr+NREQ; scanning backwards lets the nearest valid index win.
   always_comb begin
      pick = rr_ptr_q;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
            pick = IW'((int'(rr_ptr_q) + k) % NREQ);
         end
      end
   end

   // A word moves only when the owner offers one and the Fifo has room; release on last word or burst cap.
   always_comb begin
      xfer = (state_q == GRANT) && req_valid[owner_q] && !fifo_full;
      rel  = xfer && (req_last[owner_q] || (burst_cnt_q == CW'(MAXBURST - 1)));
   end

   // State register: owner, grant, burst count and round-robin pointer all live here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         rr_ptr_q    <= IW'(NREQ - 1);
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Next-state logic: grant in IDLE, count and release in GRANT (full simply stalls xfer).
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d     = GRANT;
               owner_d     = pick;
               grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               state_d     = IDLE;
               rr_ptr_d    = owner_q;
               grant_d     = '0;
               burst_cnt_d = '0;
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: only the owner sees ready and drives the Fifo; everything reads 0 in IDLE and in reset.
   always_comb begin
      req_ready  = '0;
      fifo_data  = '0;
      fifo_wrreq = xfer;
      grant      = grant_q;
      busy       = (state_q == GRANT);
      if (state_q == GRANT) begin
         req_ready = fifo_full ? '0 : grant_q;
         fifo_data = req_data[owner_q*BW +: BW];
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus hand-written multi-cycle sequences.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Traffic sequences model producers and check word order and burst boundaries.
module tb_fifo_wr_arbiter;

   localparam int NREQ     = 4;
   localparam int BW       = 32;
   localparam int MAXBURST = 16;
   localparam logic [31:0] DB = 32'hD0D0_0000;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*BW-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_last = '0;
   logic [NREQ-1:0]     req_ready;
   logic [BW-1:0]       fifo_data;
   logic                fifo_wrreq;
   logic                fifo_full = 1'b0;
   logic [NREQ-1:0]     grant;
   logic                busy;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(.NREQ(NREQ), .BW(BW), .MAXBURST(MAXBURST)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_data  (fifo_data),
      .fifo_wrreq (fifo_wrreq),
      .fifo_full  (fifo_full),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic        full;
      logic [3:0]  g;
      logic [3:0]  rdy;
      logic        wr;
      logic        bsy;
      logic [31:0] dat;
   } vec_t;

   vec_t tv[24];

   int len[NREQ];
   int sent[NREQ];
   int rxd[NREQ];
   int log_own[16];
   int log_cnt[16];
   int nlog;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                               input logic [3:0] g, input logic [3:0] r, input logic w,
                               input logic b, input logic [31:0] d);
      vec_t t;
      t.vld = v; t.lst = l; t.full = f; t.g = g; t.rdy = r; t.wr = w; t.bsy = b; t.dat = d;
      return t;
   endfunction

   function automatic int oh2i(input logic [NREQ-1:0] g);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_wrreq"}, fifo_wrreq, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_data"}, fifo_data, 0);
   endtask

   // Producer model: each requester i sends len[i] words {i, seq} as one packet.
   task automatic run_traffic(input int full_at);
      logic            prev_busy;
      logic [NREQ-1:0] acc;
      int              cyc;
      int              r;
      bit              done;
      prev_busy = 1'b0;
      cyc = 0;
      done = 1'b0;
      nlog = 0;
      for (int i = 0; i < NREQ; i++) begin sent[i] = 0; rxd[i] = 0; end
      while (!done && cyc < 400) begin
         @(negedge clock);
         for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (sent[i] < len[i]);
            req_data[i*BW +: BW] = {8'(i), 24'(sent[i])};
            req_last[i] = (sent[i] == len[i] - 1);
         end
         fifo_full = (cyc >= full_at) && (cyc < full_at + 5);
         #1;
         if (busy && !prev_busy && nlog < 16) begin
            log_own[nlog] = oh2i(grant);
            log_cnt[nlog] = 0;
            nlog++;
         end
         prev_busy = busy;
         if (fifo_full) check("ready_while_full", req_ready, 0);
         if (fifo_wrreq) begin
            check("wr_while_full", fifo_full, 0);
            r = int'(fifo_data[31:24]);
            if (r < NREQ) begin
               check($sformatf("word_seq_r%0d", r), fifo_data[23:0], 24'(rxd[r]));
               check("word_owner", grant[r], 1);
               rxd[r]++;
            end else begin
               check("word_src", r, 0);
            end
            if (nlog > 0) log_cnt[nlog-1]++;
         end
         acc = req_ready & req_valid;
         @(posedge clock);
         for (int i = 0; i < NREQ; i++) if (acc[i]) sent[i]++;
         cyc++;
         done = 1'b1;
         for (int i = 0; i < NREQ; i++) if (sent[i] != len[i]) done = 1'b0;
      end
      check("traffic_done", done, 1);
      for (int i = 0; i < NREQ; i++) check($sformatf("rx_count_r%0d", i), rxd[i], len[i]);
      @(negedge clock);
      req_valid = '0;
      req_last = '0;
      fifo_full = 1'b0;
   endtask

   initial begin
      // Reset state with requests already pending: every output must read 0.
      req_valid = 4'b1111;
      #2;
      check_idle_outputs("reset");
      @(negedge clock);
      req_valid = '0;
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) req_data[i*BW +: BW] = DB + 32'(i);

      //               vld     lst     full g       rdy     wr bsy dat
      tv[0]  = mk(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[1]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, DB + 0);
      tv[2]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, DB + 0);
      tv[3]  = mk(4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1, 1, DB + 0);
      tv[4]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[5]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[6]  = mk(4'b1111, 4'b1111, 0, 4'b0010, 4'b0010, 1, 1, DB + 1);
      tv[7]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[8]  = mk(4'b1111, 4'b1111, 0, 4'b0100, 4'b0100, 1, 1, DB + 2);
      tv[9]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[10] = mk(4'b1111, 4'b1111, 0, 4'b1000, 4'b1000, 1, 1, DB + 3);
      tv[11] = mk(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[12] = mk(4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1, DB + 0);
      tv[13] = mk(4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[14] = mk(4'b0010, 4'b0010, 1, 4'b0010, 4'b0000, 0, 1, DB + 1);
      tv[15] = mk(4'b0010, 4'b0010, 1, 4'b0010, 4'b0000, 0, 1, DB + 1);
      tv[16] = mk(4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 1, 1, DB + 1);
      tv[17] = mk(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tv[18] = mk(4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, DB + 2);
      tv[19] = mk(4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 0, 1, DB + 2);
      tv[20] = mk(4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 0, 1, DB + 2);
      tv[21] = mk(4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 0, 1, DB + 2);
      tv[22] = mk(4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 1, 1, DB + 2);
      tv[23] = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         @(negedge clock);
         req_valid = tv[i].vld;
         req_last  = tv[i].lst;
         fifo_full = tv[i].full;
         #1;
         check($sformatf("v%0d_grant", i), grant, tv[i].g);
         check($sformatf("v%0d_ready", i), req_ready, tv[i].rdy);
         check($sformatf("v%0d_wrreq", i), fifo_wrreq, tv[i].wr);
         check($sformatf("v%0d_busy", i), busy, tv[i].bsy);
         check($sformatf("v%0d_data", i), fifo_data, tv[i].dat);
      end

      // Reset pulsed mid-burst: outputs drop at once, then requester 0 wins again.
      @(negedge clock);
      req_valid = 4'b0001;
      req_last  = 4'b0000;
      @(negedge clock);
      #1;
      check("rst_pre_wrreq", fifo_wrreq, 1);
      @(negedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge clock);
      reset_n   = 1'b1;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      #1;
      check("rst_post_busy", busy, 0);
      @(negedge clock);
      #1;
      check("rst_post_grant", grant, 4'b0001);
      check("rst_post_data", fifo_data, DB + 0);
      @(negedge clock);
      req_valid = '0;
      req_last  = '0;

      // req1 sends 40 words while req2 has 5: bursts are capped at MAXBURST and alternate.
      len[0] = 0; len[1] = 40; len[2] = 5; len[3] = 0;
      run_traffic(1000);
      check("t3_nlog", nlog, 4);
      if (nlog == 4) begin
         check("t3_own0", log_own[0], 1); check("t3_cnt0", log_cnt[0], 16);
         check("t3_own1", log_own[1], 2); check("t3_cnt1", log_cnt[1], 5);
         check("t3_own2", log_own[2], 1); check("t3_cnt2", log_cnt[2], 16);
         check("t3_own3", log_own[3], 1); check("t3_cnt3", log_cnt[3], 8);
      end

      // Full for 5 cycles mid-burst: burst count freezes, so the first grant still carries 16 words.
      len[0] = 20; len[1] = 0; len[2] = 0; len[3] = 0;
      run_traffic(4);
      check("t4_nlog", nlog, 2);
      if (nlog == 2) begin
         check("t4_own0", log_own[0], 0); check("t4_cnt0", log_cnt[0], 16);
         check("t4_own1", log_own[1], 0); check("t4_cnt1", log_cnt[1], 4);
      end

      @(negedge clock);
      #1;
      check_idle_outputs("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
